// File: rtl/fir_output_decimator.sv
// Output stage of the direct-form FIR: decimates, rounds and saturates each kept
// accumulator result to OUT_WIDTH bits, then queues it in a FWFT FIFO for the consumer.
module fir_output_decimator #(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int SHIFT        = 15,
    parameter int DECIM_FACTOR = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_sample_valid,
    input  logic [IN_WIDTH-1:0]           i_fir_data,
    input  logic                          i_clear_flags,
    output logic [OUT_WIDTH-1:0]          o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_sat,
    output logic                          o_drop
);

    localparam int PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = IN_WIDTH + 1;

    localparam logic [PW-1:0]        PHASE_LAST = PW'(DECIM_FACTOR - 1);
    localparam logic [EW-1:0]        ROUND_ADD  = EW'(1) << (SHIFT - 1);
    localparam logic signed [EW-1:0] R_MAX      = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] R_MIN      = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] O_MAX      = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] O_MIN      = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [AW:0]          DEPTH_L    = (AW+1)'(FIFO_DEPTH);

    logic [PW-1:0]          phase;
    logic                   keep;
    logic signed [EW-1:0]   t_sum;
    logic signed [EW-1:0]   r_shift;
    logic [OUT_WIDTH-1:0]   rs_val;
    logic                   rs_sat;
    logic                   s1_valid;
    logic [OUT_WIDTH-1:0]   s1_data;
    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW:0]            level;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop_evt;

    assign keep = i_sample_valid && (phase == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            phase <= '0;
        end else if (i_sample_valid) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    // One guard bit above the input keeps the half-LSB rounding add from wrapping.
    assign t_sum   = $signed({i_fir_data[IN_WIDTH-1], i_fir_data}) + $signed(ROUND_ADD);
    assign r_shift = t_sum >>> SHIFT;

    always_comb begin
        rs_val = r_shift[OUT_WIDTH-1:0];
        rs_sat = 1'b0;
        if (r_shift > R_MAX) begin
            rs_val = O_MAX;
            rs_sat = 1'b1;
        end else if (r_shift < R_MIN) begin
            rs_val = O_MIN;
            rs_sat = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= rs_val;
            end
        end
    end

    assign empty    = (level == '0);
    assign full     = (level == DEPTH_L);
    assign pop      = !empty && i_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = s1_valid && (!full || pop);
    assign drop_evt = s1_valid && full && !pop;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s1_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_sat  <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            if (keep && rs_sat) begin
                o_sat <= 1'b1;
            end else if (i_clear_flags) begin
                o_sat <= 1'b0;
            end
            if (drop_evt) begin
                o_drop <= 1'b1;
            end else if (i_clear_flags) begin
                o_drop <= 1'b0;
            end
        end
    end

    assign o_valid = !empty;
    assign o_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign o_level = level;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Bench for fir_output_decimator: one instance with DECIM_FACTOR=1 and one with 4,
// both fed the same stimulus and checked against an arithmetic reference model.
module tb_fir_output_decimator;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [31:0] fir_data;
    logic        clear_flags;
    logic        ready;

    logic [15:0] data1, data4;
    logic        valid1, valid4;
    logic [3:0]  level1, level4;
    logic        sat1, sat4;
    logic        drop1, drop4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] got1[$];
    logic [15:0] got4[$];

    always #5 clk = ~clk;

    fir_output_decimator #(.DECIM_FACTOR(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_sample_valid(sample_valid), .i_fir_data(fir_data),
        .i_clear_flags(clear_flags), .o_data(data1), .o_valid(valid1), .i_ready(ready),
        .o_level(level1), .o_sat(sat1), .o_drop(drop1)
    );

    fir_output_decimator #(.DECIM_FACTOR(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_sample_valid(sample_valid), .i_fir_data(fir_data),
        .i_clear_flags(clear_flags), .o_data(data4), .o_valid(valid4), .i_ready(ready),
        .o_level(level4), .o_sat(sat4), .o_drop(drop4)
    );

    // Reference: round half-up by adding 2^14, floor-divide by 2^15, clamp to int16.
    function automatic logic [16:0] ref_rs(input logic [31:0] x);
        longint t;
        longint r;
        logic [15:0] v;
        t = longint'($signed(x)) + 64'sd16384;
        r = t >>> 15;
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        v = r[15:0];
        return {1'b0, v};
    endfunction

    // Records what each consumer takes at the coming edge, then advances one cycle.
    task automatic tick();
        if (reset && valid1 && ready) got1.push_back(data1);
        if (reset && valid4 && ready) got4.push_back(data4);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d);
        sample_valid = 1'b1;
        fir_data     = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        tick();
        reset = 1'b1;
        got1.delete();
        got4.delete();
    endtask

    task automatic test_reset();
        ready = 1'b0;
        do_reset();
        n_tests++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid1); end
        n_tests++; if (level1 !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level1); end
        n_tests++; if (sat1 !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b want 0", sat1); end
        n_tests++; if (drop1 !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0b want 0", drop1); end
        n_tests++; if (data1 !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data1); end
        n_tests++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %0b want 0", valid4); end
    endtask

    task automatic test_rounding();
        logic [31:0] ins [4];
        logic [15:0] want [4];
        ins  = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'h0001_8000};
        want = '{16'd1, 16'd0, 16'd0, 16'd3};
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ins[i]);
            n_tests++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL round_latency%0d: valid %0b want 0", i, valid1); end
            tick();
            n_tests++; if (valid1 !== 1'b1 || data1 !== want[i]) begin
                n_fail++; $display("FAIL round_out%0d: valid %0b data %h want 1 %h", i, valid1, data1, want[i]);
            end
            tick();
        end
        n_tests++; if (sat1 !== 1'b0) begin n_fail++; $display("FAIL round_sat: got %0b want 0", sat1); end
    endtask

    task automatic test_saturation();
        do_reset();
        ready = 1'b1;
        drive(32'h7FFF_FFFF);
        n_tests++; if (sat1 !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %0b want 1", sat1); end
        drive(32'h8000_0000);
        n_tests++; if (data1 !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fff", data1); end
        tick();
        n_tests++; if (data1 !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", data1); end
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        n_tests++; if (sat1 !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %0b want 0", sat1); end
        clear_flags = 1'b1;
        drive(32'h7FFF_FFFF);
        clear_flags = 1'b0;
        n_tests++; if (sat1 !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins: got %0b want 1", sat1); end
        repeat (3) tick();
    endtask

    task automatic test_decimation(input bit gaps);
        logic [15:0] exp4[$];
        logic [16:0] r;
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (k % 4 == 0) begin
                r = ref_rs(32'(k) << 15);
                exp4.push_back(r[15:0]);
            end
            drive(32'(k) << 15);
        end
        repeat (4) tick();
        n_tests++; if (got4.size() != exp4.size()) begin
            n_fail++; $display("FAIL decim_count(gaps=%0d): got %0d want %0d", gaps, got4.size(), exp4.size());
        end
        for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
            n_tests++; if (got4[i] !== exp4[i]) begin
                n_fail++; $display("FAIL decim_out%0d(gaps=%0d): got %h want %h", i, gaps, got4[i], exp4[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d [10];
        logic [16:0] r;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d[i] = $urandom;
            drive(d[i]);
        end
        tick();
        n_tests++; if (level1 !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", level1); end
        n_tests++; if (drop1 !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: got %0b want 1", drop1); end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = ref_rs(d[i]);
            n_tests++; if (valid1 !== 1'b1 || data1 !== r[15:0] || level1 !== 4'(8 - i)) begin
                n_fail++; $display("FAIL ovf_pop%0d: valid %0b data %h level %0d want 1 %h %0d",
                                   i, valid1, data1, level1, r[15:0], 8 - i);
            end
            tick();
        end
        n_tests++; if (valid1 !== 1'b0 || level1 !== 4'd0) begin
            n_fail++; $display("FAIL ovf_empty: valid %0b level %0d want 0 0", valid1, level1);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp1[$];
        logic [31:0] d;
        logic [16:0] r;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            r = ref_rs(d);
            exp1.push_back(r[15:0]);
            drive(d);
        end
        tick();
        n_tests++; if (level1 !== 4'd8) begin n_fail++; $display("FAIL fpp_fill: got %0d want 8", level1); end
        d = $urandom;
        r = ref_rs(d);
        exp1.push_back(r[15:0]);
        drive(d);
        ready = 1'b1;
        tick();
        n_tests++; if (level1 !== 4'd8 || drop1 !== 1'b0) begin
            n_fail++; $display("FAIL fpp_level_drop: level %0d drop %0b want 8 0", level1, drop1);
        end
        repeat (9) tick();
        n_tests++; if (got1.size() != 9 || valid1 !== 1'b0) begin
            n_fail++; $display("FAIL fpp_count: got %0d valid %0b want 9 0", got1.size(), valid1);
        end
        for (int i = 0; i < 9 && i < got1.size(); i++) begin
            n_tests++; if (got1[i] !== exp1[i]) begin
                n_fail++; $display("FAIL fpp_out%0d: got %h want %h", i, got1[i], exp1[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y;
        logic [16:0] r;
        do_reset();
        ready = 1'b0;
        drive(32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) drive($urandom);
        tick();
        n_tests++; if (level1 !== 4'd5 || sat1 !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: level %0d sat %0b want 5 1", level1, sat1);
        end
        drive($urandom);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_tests++; if (valid1 !== 1'b0 || level1 !== 4'd0 || sat1 !== 1'b0 || drop1 !== 1'b0 || data1 !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset: valid %0b level %0d sat %0b drop %0b data %h want 0 0 0 0 0",
                               valid1, level1, sat1, drop1, data1);
        end
        repeat (2) tick();
        n_tests++; if (level1 !== 4'd0) begin n_fail++; $display("FAIL mid_flush: level %0d want 0", level1); end
        ready = 1'b1;
        y = $urandom;
        r = ref_rs(y);
        drive(y);
        tick();
        n_tests++; if (valid4 !== 1'b1 || data4 !== r[15:0]) begin
            n_fail++; $display("FAIL mid_phase0: valid %0b data %h want 1 %h", valid4, data4, r[15:0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] exp1[$];
        logic [15:0] exp4[$];
        logic [31:0] d;
        logic [16:0] r;
        bit s1e = 1'b0;
        bit s4e = 1'b0;
        int cnt = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom;
                if ($urandom_range(0, 1) == 1) d = {{2{d[31]}}, d[29:0]};
                r = ref_rs(d);
                exp1.push_back(r[15:0]);
                s1e |= r[16];
                if (cnt % 4 == 0) begin
                    exp4.push_back(r[15:0]);
                    s4e |= r[16];
                end
                cnt++;
                drive(d);
            end else begin
                tick();
            end
        end
        ready = 1'b1;
        repeat (12) tick();
        n_tests++; if (got1.size() != exp1.size() || got4.size() != exp4.size()) begin
            n_fail++; $display("FAIL rnd_count: got %0d/%0d want %0d/%0d", got1.size(), got4.size(), exp1.size(), exp4.size());
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            n_tests++; if (got1[i] !== exp1[i]) begin n_fail++; $display("FAIL rnd_out1_%0d: got %h want %h", i, got1[i], exp1[i]); end
        end
        for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
            n_tests++; if (got4[i] !== exp4[i]) begin n_fail++; $display("FAIL rnd_out4_%0d: got %h want %h", i, got4[i], exp4[i]); end
        end
        n_tests++; if (sat1 !== s1e || sat4 !== s4e || drop1 !== 1'b0) begin
            n_fail++; $display("FAIL rnd_flags: sat1 %0b sat4 %0b drop1 %0b want %0b %0b 0", sat1, sat4, drop1, s1e, s4e);
        end
    endtask

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        fir_data     = '0;
        clear_flags  = 1'b0;
        ready        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation(1'b0);
        test_decimation(1'b1);
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
